// File: rtl/msi_dcache_ctrl_pkg.sv
// Shared types for the MSI data-cache controller.
//   blk_state_t : coherence state of one cache line
//   bus_cmd_t   : coherence bus command (encoding 3 is reserved)
package msi_dcache_ctrl_pkg;

   typedef enum logic [1:0] {
      INVALID  = 2'd0,
      SHARED   = 2'd1,
      MODIFIED = 2'd2
   } blk_state_t;

   typedef enum logic [1:0] {
      BUS_RD   = 2'd0,
      BUS_RDX  = 2'd1,
      BUS_UPGR = 2'd2
   } bus_cmd_t;

   localparam logic [1:0] BUS_CMD_RSVD = 2'd3;

endpackage

// File: rtl/msi_dcache_ctrl_if.sv
// Signal bundle between the cache controller and its environment.
//   CPU side    : addr, wr_data, we, re -> rd_data, d_rdy
//   Bus side    : bus_req, bus_cmd, bus_addr <- grant
//   Snoop side  : snp_valid, snp_cmd, snp_addr -> snp_hit, snp_flush, snp_line
//   Memory side : u_addr, u_we, u_re, u_wr_line <- u_rd_line, u_rdy
// modport master is the cache controller, modport slave is the environment
// (CPU, arbiter, other cores, unified memory).
interface msi_dcache_ctrl_if
   import msi_dcache_ctrl_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16,
   parameter int WORDS  = 4,
   parameter int SETS   = 64
);
   localparam int OFF_W  = $clog2(WORDS);
   localparam int LA_W   = ADDR_W - OFF_W;
   localparam int LINE_W = WORDS * DATA_W;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic              we;
   logic              re;
   logic [DATA_W-1:0] rd_data;
   logic              d_rdy;

   logic              bus_req;
   logic              grant;
   bus_cmd_t          bus_cmd;
   logic [LA_W-1:0]   bus_addr;

   // Plain vector so the reserved encoding can arrive and be ignored.
   logic              snp_valid;
   logic [1:0]        snp_cmd;
   logic [LA_W-1:0]   snp_addr;
   logic              snp_hit;
   logic              snp_flush;
   logic [LINE_W-1:0] snp_line;

   logic [LA_W-1:0]   u_addr;
   logic              u_we;
   logic              u_re;
   logic [LINE_W-1:0] u_wr_line;
   logic [LINE_W-1:0] u_rd_line;
   logic              u_rdy;

   modport master (
      input  addr, wr_data, we, re, grant, snp_valid, snp_cmd, snp_addr,
             u_rd_line, u_rdy,
      output rd_data, d_rdy, bus_req, bus_cmd, bus_addr, snp_hit, snp_flush,
             snp_line, u_addr, u_we, u_re, u_wr_line
   );

   modport slave (
      output addr, wr_data, we, re, grant, snp_valid, snp_cmd, snp_addr,
             u_rd_line, u_rdy,
      input  rd_data, d_rdy, bus_req, bus_cmd, bus_addr, snp_hit, snp_flush,
             snp_line, u_addr, u_we, u_re, u_wr_line
   );

endinterface

// File: rtl/msi_line_store.sv
// Tag / state / data arrays of the direct-mapped cache.
//   cpu_*  : combinational read port for the CPU-side lookup
//   snp_*  : combinational read port for snoop lookup
//   wr_*   : full-line write (tag, state, data)
//   sw_*   : state-only write used by snoops
// Tags and states reset asynchronously; data is not reset.
module msi_line_store
   import msi_dcache_ctrl_pkg::*;
#(
   parameter int TAG_W  = 5,
   parameter int IDX_W  = 6,
   parameter int LINE_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  cpu_idx,
   output logic [TAG_W-1:0]  cpu_tag,
   output blk_state_t        cpu_state,
   output logic [LINE_W-1:0] cpu_line,
   input  logic [IDX_W-1:0]  snp_idx,
   output logic [TAG_W-1:0]  snp_tag,
   output blk_state_t        snp_state,
   output logic [LINE_W-1:0] snp_line,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  blk_state_t        wr_state,
   input  logic [LINE_W-1:0] wr_line,
   input  logic              sw_en,
   input  logic [IDX_W-1:0]  sw_idx,
   input  blk_state_t        sw_state
);
   localparam int SETS = 1 << IDX_W;

   logic [TAG_W-1:0]  tags [SETS];
   blk_state_t        st   [SETS];
   logic [LINE_W-1:0] data [SETS];

   assign cpu_tag   = tags[cpu_idx];
   assign cpu_state = st[cpu_idx];
   assign cpu_line  = data[cpu_idx];
   assign snp_tag   = tags[snp_idx];
   assign snp_state = st[snp_idx];
   assign snp_line  = data[snp_idx];

   // The controller never enables both writes on the same index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SETS; i++) begin
            tags[i] <= '0;
            st[i]   <= INVALID;
         end
      end else begin
         if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            st[wr_idx]   <= wr_state;
         end
         if (sw_en)
            st[sw_idx] <= sw_state;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         data[wr_idx] <= wr_line;
   end

endmodule

// File: rtl/msi_dcache_ctrl.sv
// Direct-mapped write-back MSI data-cache controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   io         : CPU, coherence bus, snoop and memory signals (master view)
//
// state   | meaning
// IDLE    | serve CPU hits, detect misses / upgrades
// ARB     | bus_req high, waiting for grant; command issued on grant
// EVICT   | write Modified victim to memory until u_rdy
// FILL    | read requested line from memory until u_rdy, then install
// UPGR    | merge store word into Shared line, mark Modified
module msi_dcache_ctrl
   import msi_dcache_ctrl_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16,
   parameter int WORDS  = 4,
   parameter int SETS   = 64
) (
   input logic              clk,
   input logic              rst_n,
   msi_dcache_ctrl_if.master io
);
   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int LA_W   = ADDR_W - OFF_W;
   localparam int LINE_W = WORDS * DATA_W;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARB   = 3'd1;
   localparam logic [2:0] S_EVICT = 3'd2;
   localparam logic [2:0] S_FILL  = 3'd3;
   localparam logic [2:0] S_UPGR  = 3'd4;

   logic [2:0]        state, state_nx;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_we;
   bus_cmd_t          pend, pend_eff;
   logic [TAG_W-1:0]  vic_tag;
   logic [LINE_W-1:0] vic_line;
   blk_state_t        vic_state, vic_state_eff;

   logic [TAG_W-1:0]  cpu_tag, snp_tag;
   blk_state_t        cpu_state, snp_state, eff_state, wr_state, sw_state;
   logic [LINE_W-1:0] cpu_line, snp_line_a, wr_line, merged;
   logic              wr_en, sw_req, sw_en, snp_same, hit, install;
   logic              d_rdy;
   logic [DATA_W-1:0] rd_data;

   // Outside IDLE the request latched on leaving IDLE is used.
   logic              idle;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [TAG_W-1:0]  cur_tag;
   logic [IDX_W-1:0]  cur_idx;
   logic [OFF_W-1:0]  cur_off;

   assign idle      = (state == S_IDLE);
   assign cur_addr  = idle ? io.addr : req_addr;
   assign cur_wdata = idle ? io.wr_data : req_wdata;
   assign cur_tag   = cur_addr[ADDR_W-1 -: TAG_W];
   assign cur_idx   = cur_addr[OFF_W +: IDX_W];
   assign cur_off   = cur_addr[OFF_W-1:0];

   logic [TAG_W-1:0] snp_tag_in;
   logic [IDX_W-1:0] snp_idx_in;
   logic             snp_match, snp_m;

   assign snp_tag_in = io.snp_addr[LA_W-1:IDX_W];
   assign snp_idx_in = io.snp_addr[IDX_W-1:0];
   assign snp_match  = io.snp_valid && (io.snp_cmd != BUS_CMD_RSVD) &&
                       (snp_state != INVALID) && (snp_tag == snp_tag_in);
   assign snp_m      = snp_match && (snp_state == MODIFIED);
   assign sw_req     = snp_match && ((io.snp_cmd != BUS_RD) || snp_m);
   assign sw_state   = (io.snp_cmd == BUS_RD) ? SHARED : INVALID;
   assign install    = (state == S_FILL) && io.u_rdy;

   // A fill replaces whatever the snoop saw at that index, so the install
   // wins there; everywhere else the snoop wins over the CPU-side write.
   assign sw_en      = sw_req && !(install && (snp_idx_in == cur_idx));
   assign snp_same   = sw_en && (snp_idx_in == cur_idx);

   // Decisions use the state as it will be after this cycle's snoop.
   assign eff_state     = snp_same ? sw_state : cpu_state;
   assign hit           = (cpu_tag == cur_tag) && (eff_state != INVALID);
   assign vic_state_eff = snp_same ? sw_state : vic_state;
   assign pend_eff      = ((pend == BUS_UPGR) && (vic_state_eff == INVALID)) ?
                          BUS_RDX : pend;

   always_comb begin
      merged = (state == S_FILL) ? io.u_rd_line : cpu_line;
      merged[cur_off*DATA_W +: DATA_W] = cur_wdata;
   end

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      wr_state = MODIFIED;
      wr_line  = merged;
      d_rdy    = 1'b0;
      rd_data  = '0;
      case (state)
         S_IDLE: begin
            d_rdy = 1'b1;
            if (io.re || io.we) begin
               if (!hit || (io.we && (eff_state != MODIFIED))) begin
                  d_rdy    = 1'b0;
                  state_nx = S_ARB;
               end else if (io.we) begin
                  wr_en = 1'b1;
               end else begin
                  rd_data = cpu_line[cur_off*DATA_W +: DATA_W];
               end
            end
         end
         S_ARB: begin
            if (io.grant) begin
               if (pend_eff == BUS_UPGR)
                  state_nx = S_UPGR;
               else if (vic_state_eff == MODIFIED)
                  state_nx = S_EVICT;
               else
                  state_nx = S_FILL;
            end
         end
         S_EVICT: begin
            if (io.u_rdy)
               state_nx = S_FILL;
         end
         S_FILL: begin
            if (io.u_rdy) begin
               wr_en    = 1'b1;
               wr_state = req_we ? MODIFIED : SHARED;
               wr_line  = req_we ? merged : io.u_rd_line;
               state_nx = S_IDLE;
            end
         end
         S_UPGR: begin
            // If a snoop takes the line now, IDLE sees the miss and retries.
            wr_en    = !snp_same;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         req_addr  <= '0;
         req_wdata <= '0;
         req_we    <= 1'b0;
         pend      <= BUS_RD;
         vic_tag   <= '0;
         vic_line  <= '0;
         vic_state <= INVALID;
      end else begin
         state <= state_nx;
         if (idle) begin
            req_addr  <= io.addr;
            req_wdata <= io.wr_data;
            req_we    <= io.we;
            vic_tag   <= cpu_tag;
            vic_line  <= cpu_line;
            vic_state <= eff_state;
            pend      <= (hit && io.we) ? BUS_UPGR : (io.we ? BUS_RDX : BUS_RD);
         end else if (state == S_ARB) begin
            pend      <= pend_eff;
            vic_state <= vic_state_eff;
         end
      end
   end

   msi_line_store #(.TAG_W(TAG_W), .IDX_W(IDX_W), .LINE_W(LINE_W)) u_store (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_idx   (cur_idx),
      .cpu_tag   (cpu_tag),
      .cpu_state (cpu_state),
      .cpu_line  (cpu_line),
      .snp_idx   (snp_idx_in),
      .snp_tag   (snp_tag),
      .snp_state (snp_state),
      .snp_line  (snp_line_a),
      .wr_en     (wr_en),
      .wr_idx    (cur_idx),
      .wr_tag    (cur_tag),
      .wr_state  (wr_state),
      .wr_line   (wr_line),
      .sw_en     (sw_en),
      .sw_idx    (snp_idx_in),
      .sw_state  (sw_state)
   );

   assign io.d_rdy     = d_rdy;
   assign io.rd_data   = rd_data;
   assign io.bus_req   = !idle;
   assign io.bus_cmd   = ((state == S_ARB) && io.grant) ? pend_eff : BUS_RD;
   assign io.bus_addr  = ((state == S_ARB) && io.grant) ? req_addr[ADDR_W-1:OFF_W] : '0;
   assign io.u_we      = (state == S_EVICT);
   assign io.u_re      = (state == S_FILL);
   assign io.u_addr    = (state == S_EVICT) ? {vic_tag, cur_idx} :
                         (state == S_FILL)  ? req_addr[ADDR_W-1:OFF_W] : '0;
   assign io.u_wr_line = (state == S_EVICT) ? vic_line : '0;
   assign io.snp_hit   = snp_match;
   assign io.snp_flush = snp_m;
   assign io.snp_line  = snp_m ? snp_line_a : '0;

endmodule
